// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered, handshaked immediate generator for the decode pipeline.
// Takes 32-bit instruction words and produces a W-bit (XLEN) extended immediate, a
// format code and an illegal flag. A sideband tag travels with each word.
// A 2-entry skid buffer (main + skid) keeps full throughput while out_ready_i is high.
//
// Optional feature: define IMM_GEN_RVC_IMM_EN to decode compressed (RVC) immediates.
// Without it every compressed word leaves as illegal with a zero immediate.

module imm_gen_stage #(
    parameter int unsigned W     = 32,  // XLEN, 32 or 64
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_inst_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_imm_o,
    output logic [2:0]       out_fmt_o,
    output logic             out_illegal_o,
    output logic [TAG_W-1:0] out_tag_o
);

    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtZ    = 3'd6,
        FmtC    = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [W-1:0]     imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    // Every immediate is first built as a 32-bit value that is already correctly
    // extended to 32 bits (zero-extended forms have bit 31 clear), so a single
    // signed widening to W covers both sign- and zero-extension.
    logic [31:0] inst;
    logic [31:0] dec_imm32;
    fmt_e        dec_fmt;
    logic        dec_illegal;
    entry_t      dec_entry;

    assign inst = in_inst_i;

    // Combinational immediate decode of the word currently offered upstream.
    always_comb begin
        dec_imm32   = '0;
        dec_fmt     = FmtNone;
        dec_illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
`ifdef IMM_GEN_RVC_IMM_EN
            dec_fmt = FmtC;
            case ({inst[1:0], inst[15:13]})
                // C.ADDI, C.LI
                5'b01_000, 5'b01_010: begin
                    dec_imm32 = {{26{inst[12]}}, inst[12], inst[6:2]};
                end
                // C.LUI; rd == x2 is C.ADDI16SP, not decoded here
                5'b01_011: begin
                    if (inst[11:7] == 5'd2) begin
                        dec_fmt     = FmtNone;
                        dec_illegal = 1'b1;
                    end else begin
                        dec_imm32 = {{14{inst[12]}}, inst[12], inst[6:2], 12'b0};
                    end
                end
                // C.JAL, C.J
                5'b01_001, 5'b01_101: begin
                    dec_imm32 = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6],
                                 inst[7], inst[2], inst[11], inst[5:3], 1'b0};
                end
                // C.BEQZ, C.BNEZ
                5'b01_110, 5'b01_111: begin
                    dec_imm32 = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                                 inst[4:3], 1'b0};
                end
                // C.LW, C.SW: unsigned word offset
                5'b00_010, 5'b00_110: begin
                    dec_imm32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b0};
                end
                default: begin
                    dec_fmt     = FmtNone;
                    dec_illegal = 1'b1;
                end
            endcase
`else
            dec_illegal = 1'b1;
`endif
        end else begin
            case (inst[6:0])
                OpLui, OpAuipc: begin
                    dec_fmt   = FmtU;
                    dec_imm32 = {inst[31:12], 12'b0};
                end
                OpJal: begin
                    dec_fmt   = FmtJ;
                    dec_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                 inst[30:21], 1'b0};
                end
                OpBranch: begin
                    dec_fmt   = FmtB;
                    dec_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                 inst[11:8], 1'b0};
                end
                OpStore: begin
                    dec_fmt   = FmtS;
                    dec_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                end
                OpOpImm, OpJalr, OpLoad: begin
                    dec_fmt   = FmtI;
                    dec_imm32 = {{20{inst[31]}}, inst[31:20]};
                end
                OpSystem: begin
                    // funct3[2] selects the CSR immediate forms (uimm in rs1 field)
                    if (inst[14]) begin
                        dec_fmt   = FmtZ;
                        dec_imm32 = {27'b0, inst[19:15]};
                    end
                end
                OpOp: begin
                    dec_fmt = FmtNone;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    assign dec_entry = '{
        imm:     W'($signed(dec_imm32)),
        fmt:     dec_fmt,
        illegal: dec_illegal,
        tag:     in_tag_i
    };

    // ------------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------------
    entry_t main_d, main_q;
    entry_t skid_d, skid_q;
    logic   out_valid_d, out_valid_q;
    logic   skid_valid_d, skid_valid_q;
    logic   xfer_in, xfer_out;

    assign in_ready_o = ~skid_valid_q;
    assign xfer_in    = in_valid_i & ~skid_valid_q;
    assign xfer_out   = out_valid_q & out_ready_i;

    // Next-state: refill main from skid first, else load main or park in skid.
    // A refill from skid never coincides with an accept since in_ready is low then.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (xfer_out && skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (xfer_in && (!out_valid_q || out_ready_i)) begin
            main_d      = dec_entry;
            out_valid_d = 1'b1;
        end else if (xfer_in) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_imm_o     = main_q.imm;
    assign out_fmt_o     = main_q.fmt;
    assign out_illegal_o = main_q.illegal;
    assign out_tag_o     = main_q.tag;

`ifndef SYNTHESIS
    // A stalled output entry must stay put until it is taken.
    a_hold_on_stall : assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q && !out_ready_i |=> out_valid_q && $stable(main_q));

    // The skid slot is only ever used behind an occupied main slot.
    a_skid_behind_main : assert property (@(posedge clk) disable iff (!rst_n)
        skid_valid_q |-> out_valid_q);
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed decode vectors, back-to-back flow, backpressure,
// mid-stream reset and a randomized run against a queue-based reference model.

module tb_imm_gen_stage;

    localparam int unsigned W     = 32;
    localparam int unsigned TAG_W = 5;

    typedef struct {
        logic [W-1:0]     imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    imm_gen_stage #(.W(W), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_inst_i    (in_inst),
        .in_tag_i     (in_tag),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_imm_o    (out_imm),
        .out_fmt_o    (out_fmt),
        .out_illegal_o(out_illegal),
        .out_tag_o    (out_tag)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: immediates as integers assembled from instruction fields
    // ------------------------------------------------------------------------
    function automatic longint fld(input logic [31:0] x, input int hi, input int lo);
        longint v;
        v = longint'({32'b0, x});
        return (v >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    function automatic longint sx(input longint v, input int bits);
        return (v <<< (64 - bits)) >>> (64 - bits);
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] x, input logic [TAG_W-1:0] tag);
        exp_t   e;
        longint v;
        longint f3;
        logic [63:0] v64;
        v     = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tag = tag;
        if (fld(x, 1, 0) != 3) begin
`ifdef IMM_GEN_RVC_IMM_EN
            f3    = fld(x, 15, 13);
            e.fmt = 3'd7;
            if (fld(x, 1, 0) == 1 && (f3 == 0 || f3 == 2)) begin
                v = sx(fld(x, 12, 12) * 32 + fld(x, 6, 2), 6);
            end else if (fld(x, 1, 0) == 1 && f3 == 3 && fld(x, 11, 7) != 2) begin
                v = sx((fld(x, 12, 12) * 32 + fld(x, 6, 2)) * 4096, 18);
            end else if (fld(x, 1, 0) == 1 && (f3 == 1 || f3 == 5)) begin
                v = sx(fld(x, 12, 12) * 2048 + fld(x, 8, 8) * 1024 + fld(x, 10, 9) * 256
                       + fld(x, 6, 6) * 128 + fld(x, 7, 7) * 64 + fld(x, 2, 2) * 32
                       + fld(x, 11, 11) * 16 + fld(x, 5, 3) * 2, 12);
            end else if (fld(x, 1, 0) == 1 && (f3 == 6 || f3 == 7)) begin
                v = sx(fld(x, 12, 12) * 256 + fld(x, 6, 5) * 64 + fld(x, 2, 2) * 32
                       + fld(x, 11, 10) * 8 + fld(x, 4, 3) * 2, 9);
            end else if (fld(x, 1, 0) == 0 && (f3 == 2 || f3 == 6)) begin
                v = fld(x, 5, 5) * 64 + fld(x, 12, 10) * 8 + fld(x, 6, 6) * 4;
            end else begin
                e.fmt = 3'd0;
                e.ill = 1'b1;
            end
`else
            f3    = 0;
            e.ill = 1'b1;
`endif
        end else begin
            f3 = fld(x, 14, 12);
            case (fld(x, 6, 0))
                'h37, 'h17: begin e.fmt = 3'd4; v = sx(fld(x, 31, 12) * 4096, 32); end
                'h6F: begin
                    e.fmt = 3'd5;
                    v = sx(fld(x, 31, 31) * (1 << 20) + fld(x, 19, 12) * 4096
                           + fld(x, 20, 20) * 2048 + fld(x, 30, 21) * 2, 21);
                end
                'h63: begin
                    e.fmt = 3'd3;
                    v = sx(fld(x, 31, 31) * 4096 + fld(x, 7, 7) * 2048
                           + fld(x, 30, 25) * 32 + fld(x, 11, 8) * 2, 13);
                end
                'h23: begin e.fmt = 3'd2; v = sx(fld(x, 31, 25) * 32 + fld(x, 11, 7), 12); end
                'h13, 'h67, 'h03: begin e.fmt = 3'd1; v = sx(fld(x, 31, 20), 12); end
                'h73: if (f3 >= 4) begin e.fmt = 3'd6; v = fld(x, 19, 15); end
                'h33: e.fmt = 3'd0;
                default: e.ill = 1'b1;
            endcase
        end
        v64   = 64'(v);
        e.imm = v64[W-1:0];
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 13);
        if (k < 10) return {r[31:7], ops[k]};
        if (k < 12) return {r[31:2], 2'(r[1:0] % 3)};
        return r;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset out_valid: got %b need 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset in_ready: got %b need 1", in_ready); end
        n_checks++; if (out_imm !== '0) begin n_fail++;
            $display("FAIL reset out_imm: got %h need 0", out_imm); end
        n_checks++; if (out_fmt !== 3'd0 || out_illegal !== 1'b0 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset fmt/ill/tag: got %0d/%b/%0d need 0/0/0",
                     out_fmt, out_illegal, out_tag); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
            $display("FAIL post-reset ready/valid: got %b/%b need 1/0", in_ready, out_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_decode();
        logic [31:0] vin  [10] = '{32'hFFF00093, 32'h12345037, 32'hFFDFF06F, 32'h3402D073,
                                   32'h0000007F, 32'hFE512C23, 32'hFE000CE3, 32'h003100B3,
                                   32'h00000073, 32'h000050FD};
        logic [63:0] vimm [10] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000012345000,
                                   64'hFFFFFFFFFFFFFFFC, 64'h5, 64'h0,
                                   64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0,
`ifdef IMM_GEN_RVC_IMM_EN
                                   64'hFFFFFFFFFFFFFFFF};
`else
                                   64'h0};
`endif
        logic [2:0]  vfmt [10] = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd0, 3'd2, 3'd3, 3'd0, 3'd0,
`ifdef IMM_GEN_RVC_IMM_EN
                                   3'd7};
`else
                                   3'd0};
`endif
        logic        vill [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
`ifdef IMM_GEN_RVC_IMM_EN
                                   1'b0};
`else
                                   1'b1};
`endif
        logic [63:0] e64;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_inst   = vin[i];
            in_tag    = TAG_W'(i);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            e64 = vimm[i];
            n_checks++; if (out_valid !== 1'b1 || out_tag !== TAG_W'(i)) begin n_fail++;
                $display("FAIL decode[%0d] valid/tag: got %b/%0d need 1/%0d",
                         i, out_valid, out_tag, i); end
            n_checks++; if (out_imm !== e64[W-1:0]) begin n_fail++;
                $display("FAIL decode[%0d] imm of %h: got %h need %h",
                         i, vin[i], out_imm, e64[W-1:0]); end
            n_checks++; if (out_fmt !== vfmt[i] || out_illegal !== vill[i]) begin n_fail++;
                $display("FAIL decode[%0d] fmt/illegal of %h: got %0d/%b need %0d/%b",
                         i, vin[i], out_fmt, out_illegal, vfmt[i], vill[i]); end
        end
        idle_cycles(2);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [63:0] e_lui = 64'h0000000012345000;
        logic [63:0] e_jal = 64'hFFFFFFFFFFFFFFFC;
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h12345037; in_tag = 5'd1; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL b2b ready0: got %b need 1", in_ready); end
        @(negedge clk);
        n_checks++; if (out_imm !== e_lui[W-1:0] || out_fmt !== 3'd4 || out_valid !== 1'b1)
        begin n_fail++;
            $display("FAIL b2b lui: got %h fmt %0d v %b need %h fmt 4 v 1",
                     out_imm, out_fmt, out_valid, e_lui[W-1:0]); end
        in_inst = 32'hFFDFF06F; in_tag = 5'd2;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL b2b ready1: got %b need 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_imm !== e_jal[W-1:0] || out_fmt !== 3'd5 || out_tag !== 5'd2)
        begin n_fail++;
            $display("FAIL b2b jal: got %h fmt %0d tag %0d need %h fmt 5 tag 2",
                     out_imm, out_fmt, out_tag, e_jal[W-1:0]); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL b2b ready2: got %b need 1", in_ready); end
        idle_cycles(2);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        logic [31:0]      insts [3] = '{32'hABC00093, 32'h80000037, 32'h00F02023};
        logic [TAG_W-1:0] got [$];
        exp_t             e1;
        int               next;
        e1 = ref_dec(insts[0], 5'd1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = insts[0]; in_tag = 5'd1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp accept1 in_ready: got %b need 1", in_ready); end
        @(negedge clk);
        in_inst = insts[1]; in_tag = 5'd2;
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_tag !== 5'd1) begin n_fail++;
            $display("FAIL bp accept2 ready/tag: got %b/%0d need 1/1", in_ready, out_tag); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_inst = insts[2]; in_tag = 5'd3;
            #1;
            n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++;
                $display("FAIL bp stall[%0d] ready/valid: got %b/%b need 0/1",
                         c, in_ready, out_valid); end
            n_checks++; if (out_tag !== 5'd1 || out_imm !== e1.imm || out_fmt !== e1.fmt)
            begin n_fail++;
                $display("FAIL bp stall[%0d] held entry: got tag %0d imm %h need tag 1 imm %h",
                         c, out_tag, out_imm, e1.imm); end
        end
        next = 3;
        for (int c = 0; c < 10 && got.size() < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (next <= 3);
            in_inst   = insts[2];
            in_tag    = 5'd3;
            #1;
            if (out_valid) got.push_back(out_tag);
            if (in_valid && in_ready) next++;
        end
        n_checks++; if (got.size() != 3) begin n_fail++;
            $display("FAIL bp drain count: got %0d entries need 3", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== TAG_W'(i + 1)) begin n_fail++;
                $display("FAIL bp order[%0d]: got tag %0d need %0d", i, got[i], i + 1); end
        end
        idle_cycles(2);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_midstream();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093; in_tag = 5'd7;
        @(negedge clk);
        in_tag = 5'd8;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL midrst full: in_ready got %b need 0", in_ready); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL midrst async: valid/ready got %b/%b need 0/1", out_valid, in_ready); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00200093; in_tag = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd9) begin n_fail++;
            $display("FAIL midrst first out: valid/tag got %b/%0d need 1/9", out_valid, out_tag); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL midrst stale entry: out_valid got %b need 0", out_valid); end
        idle_cycles(1);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        exp_t q [$];
        exp_t e;
        logic xin, xout;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = gen_inst();
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++; if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
                n_fail++;
                $display("FAIL rand[%0d] ready/valid: got %b/%b need %b/%b",
                         c, in_ready, out_valid, q.size() < 2, q.size() > 0); end
            xout = out_ready && (q.size() > 0);
            xin  = in_valid && (q.size() < 2);
            if (xout) begin
                e = q.pop_front();
                n_checks++;
                if (out_imm !== e.imm || out_fmt !== e.fmt || out_illegal !== e.ill ||
                    out_tag !== e.tag) begin
                    n_fail++;
                    $display("FAIL rand[%0d] entry: got imm %h fmt %0d ill %b tag %0d need imm %h fmt %0d ill %b tag %0d",
                             c, out_imm, out_fmt, out_illegal, out_tag,
                             e.imm, e.fmt, e.ill, e.tag);
                end
            end
            if (xin) q.push_back(ref_dec(in_inst, in_tag));
        end
        idle_cycles(3);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
